// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the dmem load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    LDX  = 2'd2,
    WR   = 2'd3
  } lsu_state_t;

  typedef enum logic {
    KIND_LOAD  = 1'b0,
    KIND_STORE = 1'b1
  } lsu_kind_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    lsu_kind_t   kind;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // Read/write conflict, no operation, or a funct3 that has no RV32I meaning.
  function automatic logic lsu_bad_op(input logic rd, input logic wr, input logic [2:0] f3);
    logic bad;
    bad = (rd == wr);
    if (rd && !wr) bad = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    if (wr && !rd) bad = !(f3 inside {F3_B, F3_H, F3_W});
    return bad;
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] alo);
    return ((f3[1:0] == 2'b10) && (alo != 2'b00)) || ((f3[1:0] == 2'b01) && alo[0]);
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: load byte/half extraction with extension, and
// sub-word store merge into the word read back from dmem.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic signed [7:0]  byte_sel;
  logic signed [15:0] half_sel;
  logic signed [31:0] byte_sx;
  logic signed [31:0] half_sx;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  assign byte_sx = 32'(byte_sel);
  assign half_sx = 32'(half_sel);

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_B:    load_data = byte_sx;
      F3_BU:   load_data = {24'd0, byte_sel};
      F3_H:    load_data = half_sx;
      F3_HU:   load_data = {16'd0, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Halves use addr_lo[1] only, so an unaligned half lands on its aligned lane.
  always_comb begin
    store_data = rdata;
    case (funct3[1:0])
      2'b00:   store_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01:   store_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// MEM-stage load/store initiator for a word-addressed dmem without byte enables.
// Define MISALIGN_TRAP_EN to report misaligned accesses as errors instead of aligning them.
module dmem_lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [31:0]           i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_load_valid,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_store_done,
  output logic                  o_access_err,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata
);

  lsu_state_t  state;
  lsu_req_t    req_q;
  logic        req_bad;
  logic [31:0] lane_load;
  logic [31:0] lane_store;
  logic        unused_addr_hi;

  always_comb begin
    req_bad = lsu_bad_op(i_mem_read, i_mem_write, i_funct3);
`ifdef MISALIGN_TRAP_EN
    if (lsu_misaligned(i_funct3, i_addr[1:0])) req_bad = 1'b1;
`endif
  end

  lsu_byte_lane u_lane (
    .funct3     (req_q.funct3),
    .addr_lo    (req_q.addr[1:0]),
    .rdata      (i_dmem_rdata),
    .wdata      (req_q.wdata),
    .load_data  (lane_load),
    .store_data (lane_store)
  );

  // dmem strobes come straight from state so a reset can never leave a write pending.
  assign o_req_ready  = (state == IDLE);
  assign o_dmem_we    = (state == WR);
  assign o_dmem_addr  = (state == IDLE) ? '0 : req_q.addr[ADDR_WIDTH+1:2];
  assign o_dmem_wdata = lane_store;

  assign unused_addr_hi = ^req_q.addr[31:ADDR_WIDTH+2];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      req_q        <= '0;
      o_load_valid <= 1'b0;
      o_load_data  <= '0;
      o_store_done <= 1'b0;
      o_access_err <= 1'b0;
    end else begin
      o_load_valid <= 1'b0;
      o_store_done <= 1'b0;
      o_access_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid) begin
            req_q.kind   <= i_mem_write ? KIND_STORE : KIND_LOAD;
            req_q.funct3 <= i_funct3;
            req_q.addr   <= i_addr;
            req_q.wdata  <= i_wdata;
            if (req_bad) begin
              o_access_err <= 1'b1;
            end else if (i_mem_write && (i_funct3 == F3_W)) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          state <= (req_q.kind == KIND_STORE) ? WR : LDX;
        end
        LDX: begin
          o_load_data  <= lane_load;
          o_load_valid <= 1'b1;
          state        <= IDLE;
        end
        WR: begin
          o_store_done <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: byte-array reference model feeds an expectation
// queue; a negedge monitor pops and checks each pulse against it.
module tb_dmem_lsu;

  localparam int AW = 9;

  logic        clk = 1'b0;
  logic        rst_n, preload;
  logic        req_valid, req_ready, mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, load_data, dmem_wdata, dmem_rdata;
  logic        load_valid, store_done, access_err, dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0] mem [0:511];

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_wdata      (wdata),
    .o_load_valid (load_valid),
    .o_load_data  (load_data),
    .o_store_done (store_done),
    .o_access_err (access_err),
    .o_dmem_we    (dmem_we),
    .o_dmem_addr  (dmem_addr),
    .o_dmem_wdata (dmem_wdata),
    .i_dmem_rdata (dmem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 16) return 32'h8070F0A5;
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // dmem: registered read, single write enable
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
    end else if (dmem_we) begin
      mem[dmem_addr] <= dmem_wdata;
    end
    dmem_rdata <= mem[dmem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 load, 1 store, 2 error
    logic [31:0] data;
    logic [31:0] waddr;
    int          lat;
    int          acc;
    int          wr0;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  ref_mem [0:2047];
  int          tests = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, expv, cyc);
    end
  endtask

  // Reference: byte-addressed memory, little endian, wrap at 2 KiB.
  function automatic exp_t model(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          size;
    logic [10:0] ea;
    logic [10:0] wb;
    logic [63:0] v;
    logic        bad;
    e.kind = 2; e.data = '0; e.waddr = '0; e.lat = 1; e.acc = 0; e.wr0 = 0;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad = (rd == wr) || (rd && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) || (wr && f3 >= 3'd3);
`ifdef MISALIGN_TRAP_EN
    if ((int'(a[1:0]) % size) != 0) bad = 1'b1;
`endif
    if (bad) return e;
    ea = a[10:0] & ~11'(size - 1);
    if (rd) begin
      v = '0;
      for (int i = 0; i < size; i++) v = v | (64'(ref_mem[ea + 11'(i)]) << (8 * i));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
      e.kind = 0; e.data = v[31:0]; e.lat = 3;
    end else begin
      for (int i = 0; i < size; i++) ref_mem[ea + 11'(i)] = wd[8*i +: 8];
      wb = ea & 11'h7FC;
      e.kind = 1;
      e.waddr = 32'(wb >> 2);
      e.data = {ref_mem[wb + 11'd3], ref_mem[wb + 11'd2], ref_mem[wb + 11'd1], ref_mem[wb]};
      e.lat = (size == 4) ? 2 : 3;
    end
    return e;
  endfunction

  // Monitor
  initial begin
    exp_t e;
    int   pulses;
    int   gk;
    forever begin
      @(negedge clk);
      if (rst_n && !preload) begin
        if (dmem_we) begin
          wr_cnt++;
          last_wa = 32'(dmem_addr);
          last_wd = dmem_wdata;
        end
        pulses = int'(load_valid) + int'(store_done) + int'(access_err);
        if (pulses != 0) begin
          if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_pulse: got lv=%b sd=%b err=%b expected none", load_valid, store_done, access_err);
          end else begin
            e = q.pop_front();
            gk = access_err ? 2 : (store_done ? 1 : 0);
            chk("pulse_onehot", 32'(pulses), 32'd1);
            chk("kind", 32'(gk), 32'(e.kind));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("write_count", 32'(wr_cnt - e.wr0), (e.kind == 1) ? 32'd1 : 32'd0);
            if (e.kind == 0) chk("load_data", load_data, e.data);
            if (e.kind == 1) begin
              chk("wr_addr", last_wa, e.waddr);
              chk("wr_data", last_wd, e.data);
            end
          end
        end
      end
    end
  end

  // Called at a negedge with o_req_ready=1; returns at the next negedge where it is 1 again.
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input bit hold);
    exp_t e;
    int   busy;
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    e = model(rd, wr, f3, a, wd);
    e.acc = cyc;
    e.wr0 = wr_cnt;
    q.push_back(e);
    if (!hold) req_valid = 1'b0;
    busy = 0;
    @(negedge clk);
    while (!req_ready && busy < 10) begin
      busy++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(busy), 32'(e.lat - 1));
    chk("pulse_at_ready", 32'(load_valid | store_done | access_err), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    logic        rd, wr;
    int          sel;
    rst_n = 1'b0; preload = 1'b1; req_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 512; i++) begin
      a = init_word(i);
      for (int b = 0; b < 4; b++) ref_mem[11'(4 * i + b)] = a[8*b +: 8];
    end
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_store_done", 32'(store_done), 32'd0);
    chk("rst_access_err", 32'(access_err), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_addr", 32'(dmem_addr), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    preload = 1'b0; rst_n = 1'b1;
    @(negedge clk);

    // load extension, sub-word and word stores, misaligned word load
    do_req(1, 0, 3'b000, 32'h40, 32'h0, 0);
    do_req(1, 0, 3'b100, 32'h41, 32'h0, 0);
    do_req(1, 0, 3'b001, 32'h42, 32'h0, 0);
    do_req(1, 0, 3'b101, 32'h40, 32'h0, 0);
    do_req(1, 0, 3'b010, 32'h40, 32'h0, 0);
    do_req(0, 1, 3'b000, 32'h42, 32'h000000CC, 0);
    do_req(0, 1, 3'b001, 32'h40, 32'h00001234, 0);
    do_req(0, 1, 3'b010, 32'h44, 32'hDEADBEEF, 0);
    do_req(1, 0, 3'b010, 32'h44, 32'h0, 0);
    do_req(1, 0, 3'b010, 32'h41, 32'h0, 0);

    // reset while the SB read is in flight
    req_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b000; addr = 32'h40; wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_ready", 32'(req_ready), 32'd0);
    chk("rmw_rd_addr", 32'(dmem_addr), 32'h10);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rmw_rst_ready", 32'(req_ready), 32'd1);
    chk("rmw_rst_we", 32'(dmem_we), 32'd0);
    chk("rmw_rst_load_data", load_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rmw_after_we", 32'(dmem_we), 32'd0);
    do_req(1, 0, 3'b010, 32'h40, 32'h0, 0);

    // back-to-back with valid held high, including a read/write conflict
    do_req(1, 0, 3'b010, 32'h40, 32'h0, 1);
    do_req(0, 1, 3'b000, 32'h43, 32'h000000AB, 1);
    do_req(1, 1, 3'b010, 32'h40, 32'h0, 1);
    do_req(1, 0, 3'b101, 32'h42, 32'h0, 1);
    do_req(0, 1, 3'b010, 32'h48, 32'h13579BDF, 1);
    do_req(1, 0, 3'b000, 32'h43, 32'h0, 1);
    req_valid = 1'b0;
    @(negedge clk);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      sel = $urandom_range(0, 19);
      if (sel == 0) begin rd = 1; wr = 1; end
      else if (sel == 1) begin rd = 0; wr = 0; end
      else if (sel < 11) begin rd = 1; wr = 0; end
      else begin rd = 0; wr = 1; end
      if ($urandom_range(0, 6) == 0) f3 = 3'($urandom_range(0, 7));
      else if (rd && !wr) begin
        sel = $urandom_range(0, 4);
        f3 = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b001 : (sel == 2) ? 3'b010 : (sel == 3) ? 3'b100 : 3'b101;
      end else f3 = 3'($urandom_range(0, 2));
      a = 32'h40 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFFF800);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      do_req(rd, wr, f3, a, $urandom, bit'($urandom_range(0, 1)));
    end
    req_valid = 1'b0;

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
